// File: rtl/song_recorder_pkg.sv
// Shared constants for the free-play song recorder.
// Recorder state encodings, rest note code and field widths.
package song_recorder_pkg;

    localparam int OCTAVE_BITS = 3;
    localparam int NOTE_BITS   = 3;
    localparam int LENGTH_BITS = 3;

    typedef enum logic [1:0] {
        REC_IDLE  = 2'b00,
        REC_ARMED = 2'b01,
        REC_REC   = 2'b10,
        REC_DONE  = 2'b11
    } rec_state_t;

    localparam logic [NOTE_BITS-1:0] REST_NOTE = '0;

endpackage

// File: rtl/song_recorder_track_ram.sv
// Track buffer: DEPTH x W storage, synchronous write, async read.
// Ports: clk, i_we/i_waddr/i_wdata write side, i_raddr/o_rdata read.
module track_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int W      = 9
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/song_recorder.sv
// Records (octave, note, length) events plus inserted rests into a
// track buffer and replays them through a masked async read port.
// Ports: clk, rst_n, en, start/stop/clear pulses, note_valid with
// octave_in/note_in/length_in, beat_tick, rd_addr -> rd_* fields,
// status track, state, recording, full, overflow.
module song_recorder
    import song_recorder_pkg::*;
#(
    parameter int OCTAVE_W   = OCTAVE_BITS,
    parameter int NOTE_W     = NOTE_BITS,
    parameter int LENGTH_W   = LENGTH_BITS,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int REST_TICKS = 8,
    parameter logic [OCTAVE_W-1:0] REST_OCT = 3'b100,
    parameter logic [LENGTH_W-1:0] REST_LEN = 3'd2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                note_valid,
    input  logic [OCTAVE_W-1:0] octave_in,
    input  logic [NOTE_W-1:0]   note_in,
    input  logic [LENGTH_W-1:0] length_in,
    input  logic                beat_tick,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [OCTAVE_W-1:0] rd_octave,
    output logic [NOTE_W-1:0]   rd_note,
    output logic [LENGTH_W-1:0] rd_length,
    output logic [ADDR_W:0]     track,
    output logic [1:0]          state,
    output logic                recording,
    output logic                full,
    output logic                overflow
);

    localparam int ENTRY_W = OCTAVE_W + NOTE_W + LENGTH_W;
    localparam int CNT_W   = (REST_TICKS > 1) ? $clog2(REST_TICKS) : 1;
    localparam logic [CNT_W-1:0] REST_LAST = CNT_W'(REST_TICKS - 1);
    localparam logic [ADDR_W:0]  TRACK_MAX = (ADDR_W+1)'(DEPTH);

    rec_state_t         r_state;
    rec_state_t         w_next;
    logic [ADDR_W:0]    r_track;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic               w_full;
    logic               w_active;
    logic               w_note_acc;
    logic               w_tick_rec;
    logic               w_rest_due;
    logic               w_wr_req;
    logic               w_we;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    logic               w_rd_hit;

    assign w_full     = (r_track == TRACK_MAX);
    assign w_active   = en & ~clear;
    assign w_note_acc = w_active & note_valid
                      & (note_in != REST_NOTE)
                      & ((r_state == REC_ARMED) | (r_state == REC_REC));
    assign w_tick_rec = w_active & beat_tick & (r_state == REC_REC);
    // A note in the same cycle as a due rest wins; the rest is dropped.
    assign w_rest_due = w_tick_rec & (r_cnt == REST_LAST) & ~w_note_acc;
    assign w_wr_req   = w_note_acc | w_rest_due;
    assign w_we       = w_wr_req & ~w_full;
    assign w_wdata    = w_note_acc ? {octave_in, note_in, length_in}
                                   : {REST_OCT, REST_NOTE, REST_LEN};

    track_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_track[ADDR_W-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (rd_addr),
        .o_rdata (w_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= REC_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = (en & start) ? REC_ARMED : REC_IDLE;
        end else if (!en) begin
            w_next = REC_IDLE;
        end else begin
            unique case (r_state)
                REC_IDLE:  if (start) w_next = REC_ARMED;
                REC_ARMED: begin
                    if (stop)      w_next = REC_DONE;
                    else if (w_we) w_next = REC_REC;
                end
                REC_REC:   if (stop)  w_next = REC_DONE;
                REC_DONE:  if (start) w_next = REC_ARMED;
                default:   w_next = REC_IDLE;
            endcase
        end
    end

    // Track length, overflow flag and silence counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_track <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (clear)     r_track <= '0;
            else if (w_we) r_track <= r_track + 1'b1;

            if (clear)                    r_ovf <= 1'b0;
            else if (w_wr_req & w_full)   r_ovf <= 1'b1;

            if (clear | ~en)      r_cnt <= '0;
            else if (w_note_acc)  r_cnt <= '0;
            else if (w_tick_rec)  r_cnt <= (r_cnt == REST_LAST) ? '0
                                         : r_cnt + 1'b1;
        end
    end

    // Outputs
    always_comb begin
        state     = r_state;
        recording = (r_state == REC_REC);
        full      = w_full;
        track     = r_track;
        overflow  = r_ovf;
    end

    // Unwritten slots read as a silent entry, never stale RAM data.
    assign w_rd_hit = ({1'b0, rd_addr} < r_track);
    assign {rd_octave, rd_note, rd_length} = w_rd_hit ? w_rdata
        : {REST_OCT, REST_NOTE, {LENGTH_W{1'b0}}};

endmodule

// File: tb/tb_song_recorder.sv
// Self-checking bench for song_recorder: directed scenarios plus
// randomized traffic against a queue-based track model.
module tb_song_recorder;

    logic       clk = 1'b0;
    logic       rst_n, en, start, stop, clear, note_valid, beat_tick;
    logic [2:0] octave_in, note_in, length_in;
    logic [5:0] rd_addr;
    logic [2:0] rd_octave, rd_note, rd_length;
    logic [6:0] track;
    logic [1:0] state;
    logic       recording, full, overflow;

    always #5 clk = ~clk;

    song_recorder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .note_valid (note_valid),
        .octave_in  (octave_in),
        .note_in    (note_in),
        .length_in  (length_in),
        .beat_tick  (beat_tick),
        .rd_addr    (rd_addr),
        .rd_octave  (rd_octave),
        .rd_note    (rd_note),
        .rd_length  (rd_length),
        .track      (track),
        .state      (state),
        .recording  (recording),
        .full       (full),
        .overflow   (overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_REC   = 2;
    localparam int S_DONE  = 3;
    localparam logic [8:0] EMPTY_RD = 9'b100_000_000;
    localparam logic [8:0] REST_ENT = 9'b100_000_010;

    logic [8:0] m_q[$];
    int         m_st;
    int         m_sil;
    bit         m_ovf;

    function automatic logic [11:0] obs();
        return {state, track, full, recording, overflow};
    endfunction

    function automatic logic [11:0] expv();
        return {2'(m_st), 7'(m_q.size()), m_q.size() == 64,
                m_st == S_REC, m_ovf};
    endfunction

    function automatic logic [8:0] m_rd(input int a);
        return (a < m_q.size()) ? m_q[a] : EMPTY_RD;
    endfunction

    function automatic logic [8:0] rdv();
        return {rd_octave, rd_note, rd_length};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_st  = S_IDLE;
        m_sil = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input bit e, input bit s, input bit p,
                              input bit c, input bit nv,
                              input logic [2:0] o, input logic [2:0] n,
                              input logic [2:0] l, input bit bt);
        bit acc, rest, wrote;
        if (c) begin
            m_q.delete();
            m_ovf = 0;
            m_sil = 0;
            m_st  = (e && s) ? S_ARMED : S_IDLE;
            return;
        end
        if (!e) begin
            m_st  = S_IDLE;
            m_sil = 0;
            return;
        end
        acc   = nv && n != 0 && (m_st == S_ARMED || m_st == S_REC);
        rest  = !acc && m_st == S_REC && bt && m_sil == 7;
        wrote = 0;
        if (acc || rest) begin
            if (m_q.size() < 64) begin
                m_q.push_back(acc ? {o, n, l} : REST_ENT);
                wrote = 1;
            end else begin
                m_ovf = 1;
            end
        end
        if (acc) m_sil = 0;
        else if (m_st == S_REC && bt) m_sil = (m_sil == 7) ? 0 : m_sil + 1;
        case (m_st)
            S_IDLE:  if (s) m_st = S_ARMED;
            S_ARMED: if (p) m_st = S_DONE; else if (wrote) m_st = S_REC;
            S_REC:   if (p) m_st = S_DONE;
            default: if (s) m_st = S_ARMED;
        endcase
    endtask

    task automatic cycle(input bit s, input bit p, input bit c,
                         input bit nv, input logic [2:0] o,
                         input logic [2:0] n, input logic [2:0] l,
                         input bit bt);
        @(negedge clk);
        start = s; stop = p; clear = c; note_valid = nv;
        octave_in = o; note_in = n; length_in = l; beat_tick = bt;
        @(posedge clk);
        model_step(en, s, p, c, nv, o, n, l, bt);
        #1;
    endtask

    task automatic note(input logic [2:0] o, input logic [2:0] n,
                        input logic [2:0] l);
        cycle(0, 0, 0, 1, o, n, l, 0);
    endtask

    task automatic tick();
        cycle(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 1);
    endtask

    task automatic rnd_note();
        note(3'($urandom), 3'($urandom_range(1, 7)), 3'($urandom));
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; start = 0; stop = 0; clear = 0;
        note_valid = 0; beat_tick = 0; rd_addr = '0;
        octave_in = '0; note_in = '0; length_in = '0;
        model_reset();
        #12;
        n_vec++;
        if (obs() !== 12'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs(), 12'd0);
        end
        @(negedge clk);
        rst_n = 1; en = 1;
        cycle(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        repeat (5) rnd_note();
        n_vec++;
        if (obs() !== expv() || track !== 7'd5) begin
            n_err++;
            $display("FAIL rec5: got %h expected %h", obs(), expv());
        end
        #2 rst_n = 0;
        #1 model_reset();
        n_vec++;
        if (obs() !== 12'd0) begin
            n_err++;
            $display("FAIL async_reset: got %h expected %h", obs(), 12'd0);
        end
        rd_addr = 6'd0;
        #1;
        n_vec++;
        if (rdv() !== EMPTY_RD) begin
            n_err++;
            $display("FAIL reset_rd0: got %h expected %h", rdv(), EMPTY_RD);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        cycle(0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0);
        cycle(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        n_vec++;
        if (state !== 2'b01) begin
            n_err++;
            $display("FAIL basic_armed: got %b expected 01", state);
        end
        note(3'd4, 3'd1, 3'd3);
        n_vec++;
        if (state !== 2'b10 || track !== 7'd1) begin
            n_err++;
            $display("FAIL basic_rec: got %b/%0d expected 10/1", state, track);
        end
        note(3'd5, 3'd3, 3'd2);
        cycle(0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        n_vec++;
        if (obs() !== expv() || state !== 2'b11 || track !== 7'd2) begin
            n_err++;
            $display("FAIL basic_done: got %h expected %h", obs(), expv());
        end
        rd_addr = 6'd1;
        #1;
        n_vec++;
        if (rdv() !== 9'b101_011_010) begin
            n_err++;
            $display("FAIL basic_rd1: got %h expected %h", rdv(), 9'b101_011_010);
        end
        rd_addr = 6'd2;
        #1;
        n_vec++;
        if (rdv() !== EMPTY_RD) begin
            n_err++;
            $display("FAIL basic_rd2: got %h expected %h", rdv(), EMPTY_RD);
        end
    endtask

    task automatic test_rest();
        int base;
        cycle(0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0);
        cycle(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        rnd_note();
        base = m_q.size();
        repeat (16) tick();
        n_vec++;
        if (track !== 7'(base + 2) || obs() !== expv()) begin
            n_err++;
            $display("FAIL rest_count: got %0d expected %0d", track, base + 2);
        end
        for (int a = base; a < base + 2; a++) begin
            rd_addr = 6'(a);
            #1;
            n_vec++;
            if (rdv() !== REST_ENT) begin
                n_err++;
                $display("FAIL rest_entry%0d: got %h expected %h", a, rdv(), REST_ENT);
            end
        end
    endtask

    task automatic test_collision();
        cycle(0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0);
        cycle(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        rnd_note();
        repeat (7) tick();
        cycle(0, 0, 0, 1, 3'd4, 3'd5, 3'd1, 1);
        rd_addr = 6'd1;
        #1;
        n_vec++;
        if (track !== 7'd2 || rdv() !== 9'b100_101_001) begin
            n_err++;
            $display("FAIL coll_note: got %0d/%h expected 2/%h", track, rdv(), 9'b100_101_001);
        end
        repeat (7) tick();
        n_vec++;
        if (track !== 7'd2) begin
            n_err++;
            $display("FAIL coll_norest: got %0d expected 2", track);
        end
        tick();
        rd_addr = 6'd2;
        #1;
        n_vec++;
        if (track !== 7'd3 || rdv() !== REST_ENT) begin
            n_err++;
            $display("FAIL coll_rest: got %0d/%h expected 3/%h", track, rdv(), REST_ENT);
        end
    endtask

    task automatic test_full();
        logic [8:0] e63;
        cycle(0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0);
        cycle(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        repeat (64) rnd_note();
        e63 = m_q[63];
        note(~e63[8:6], (e63[5:3] == 3'd7) ? 3'd1 : 3'd7, ~e63[2:0]);
        n_vec++;
        if (obs() !== expv() || !full || !overflow || track !== 7'd64) begin
            n_err++;
            $display("FAIL full_state: got %h expected %h", obs(), expv());
        end
        rd_addr = 6'd63;
        #1;
        n_vec++;
        if (rdv() !== e63) begin
            n_err++;
            $display("FAIL full_e63: got %h expected %h", rdv(), e63);
        end
        cycle(0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0);
        n_vec++;
        if (obs() !== 12'd0) begin
            n_err++;
            $display("FAIL full_clear: got %h expected %h", obs(), 12'd0);
        end
    endtask

    task automatic test_append_en();
        cycle(0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0);
        cycle(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        repeat (3) rnd_note();
        cycle(0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        cycle(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        n_vec++;
        if (state !== 2'b01 || track !== 7'd3) begin
            n_err++;
            $display("FAIL app_armed: got %b/%0d expected 01/3", state, track);
        end
        note(3'd3, 3'd7, 3'd4);
        rd_addr = 6'd3;
        #1;
        n_vec++;
        if (rdv() !== 9'b011_111_100 || track !== 7'd4 || obs() !== expv()) begin
            n_err++;
            $display("FAIL app_note: got %h/%0d expected %h/4", rdv(), track, 9'b011_111_100);
        end
        en = 0;
        cycle(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
        n_vec++;
        if (state !== 2'b00 || track !== 7'd4) begin
            n_err++;
            $display("FAIL en_low: got %b/%0d expected 00/4", state, track);
        end
        en = 1;
    endtask

    task automatic test_random();
        int cl;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 99) != 0);
            cl = (i < 1500) ? 1000 : 80;
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, cl - 1) == 0, $urandom_range(0, 2) == 0,
                  3'($urandom), 3'($urandom), 3'($urandom),
                  $urandom_range(0, 1) == 1);
            n_vec++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL rnd_status@%0d: got %h expected %h", i, obs(), expv());
            end
            rd_addr = 6'($urandom);
            #1;
            n_vec++;
            if (rdv() !== m_rd(int'(rd_addr))) begin
                n_err++;
                $display("FAIL rnd_rd@%0d: got %h expected %h", i, rdv(), m_rd(int'(rd_addr)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rest();
        test_collision();
        test_full();
        test_append_en();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
